pwm_sine_multich: RTL and testbench

// - Multi-channel sinusoidal PWM generator: one shared R-bit carrier and a 36-step sine table.
// - NCH outputs, each offset by PHASE steps, so the defaults give 3-phase at 120 deg.
// - Runtime frequency divider (n_div) and amplitude scaling (amp).
// - Glitch-free duty updates: duty changes only at a carrier boundary.
// - Sits between the control/UI registers and the output pins or filter stage.

---
 rtl/pwm_sine_multich.sv | 160 ++++++++++++++++
 tb/tb_pwm_sine_multich.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sine_multich.sv
// Multi-channel sinusoidal PWM generator.
// One shared R-bit carrier drives NCH comparators. Each channel's duty comes
// from a 36-entry sine ROM, scaled by a latched amplitude and offset by
// c*PHASE table steps. Duty, amplitude and divider values only change at a
// carrier wrap, so an output pulse is never cut short or stretched mid-period.
module pwm_sine_multich #(
    parameter int R     = 6,
    parameter int NCH   = 3,
    parameter int PHASE = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [11:0]      n_div,
    input  logic [8:0]       amp,
    output logic [NCH-1:0]   pwm_out,
    output logic [5:0]       step_idx,
    output logic             period_tick,
    output logic             step_tick
);

    localparam logic [R-1:0] CNT_MAX = {R{1'b1}};

    // Quarter-wave-free full sine ROM: round(1023*(0.5+0.5*sin(2*pi*k/36))).
    function automatic logic [9:0] sin_q(input logic [5:0] k);
        logic [9:0] v;
        case (k)
            6'd0:  v = 10'd512;  6'd1:  v = 10'd600;  6'd2:  v = 10'd686;
            6'd3:  v = 10'd767;  6'd4:  v = 10'd840;  6'd5:  v = 10'd903;
            6'd6:  v = 10'd954;  6'd7:  v = 10'd992;  6'd8:  v = 10'd1015;
            6'd9:  v = 10'd1023; 6'd10: v = 10'd1015; 6'd11: v = 10'd992;
            6'd12: v = 10'd954;  6'd13: v = 10'd903;  6'd14: v = 10'd840;
            6'd15: v = 10'd767;  6'd16: v = 10'd686;  6'd17: v = 10'd600;
            6'd18: v = 10'd512;  6'd19: v = 10'd423;  6'd20: v = 10'd337;
            6'd21: v = 10'd256;  6'd22: v = 10'd183;  6'd23: v = 10'd120;
            6'd24: v = 10'd69;   6'd25: v = 10'd31;   6'd26: v = 10'd8;
            6'd27: v = 10'd0;    6'd28: v = 10'd8;    6'd29: v = 10'd31;
            6'd30: v = 10'd69;   6'd31: v = 10'd120;  6'd32: v = 10'd183;
            6'd33: v = 10'd256;  6'd34: v = 10'd337;  6'd35: v = 10'd423;
            default: v = 10'd0;
        endcase
        return v;
    endfunction

    // Scale the table entry around mid-scale by amp/256 and reduce to R bits.
    // The 21-bit product holds +/-512*256 without overflow.
    function automatic logic [R-1:0] duty_of(input logic [5:0] k, input logic [8:0] a);
        logic signed [10:0] s;
        logic signed [20:0] s_ext;
        logic signed [20:0] a_ext;
        logic signed [20:0] prod;
        logic signed [20:0] d;
        logic [9:0]         d10;
        s     = $signed({1'b0, sin_q(k)}) - 11'sd512;
        s_ext = {{10{s[10]}}, s};
        a_ext = {12'd0, a};
        prod  = s_ext * a_ext;
        d     = 21'sd512 + (prod >>> 8);
        if (d < 21'sd0) begin
            d10 = 10'd0;
        end else if (d > 21'sd1023) begin
            d10 = 10'd1023;
        end else begin
            d10 = d[9:0];
        end
        return d10[9:10-R];
    endfunction

    // Table index of channel c for a given channel-0 step.
    function automatic logic [5:0] chan_idx(input logic [5:0] st, input int c);
        int t;
        t = (int'(st) + c * PHASE) % 36;
        return t[5:0];
    endfunction

    logic [R-1:0]          cnt_q,     cnt_d;
    logic [11:0]           nper_q,    nper_d;
    logic [5:0]            step_q,    step_d;
    logic [11:0]           n_lat_q,   n_lat_d;
    logic [8:0]            amp_lat_q, amp_lat_d;
    logic [NCH-1:0][R-1:0] duty_q,    duty_d;

    logic       wrap_s;
    logic       step_adv_s;
    logic [5:0] step_next_s;
    logic [8:0] amp_clamp_s;
    logic [11:0] ndiv_eff_s;

    // Next-state logic: carrier count, step sequencing and wrap-time latching.
    always_comb begin
        cnt_d       = cnt_q;
        nper_d      = nper_q;
        step_d      = step_q;
        n_lat_d     = n_lat_q;
        amp_lat_d   = amp_lat_q;
        duty_d      = duty_q;
        wrap_s      = en && (cnt_q == CNT_MAX);
        step_adv_s  = wrap_s && (nper_q == (n_lat_q - 12'd1));
        amp_clamp_s = (amp > 9'd256) ? 9'd256 : amp;
        ndiv_eff_s  = (n_div == 12'd0) ? 12'd1 : n_div;
        if (step_adv_s) begin
            step_next_s = (step_q == 6'd35) ? 6'd0 : step_q + 6'd1;
        end else begin
            step_next_s = step_q;
        end
        if (en) begin
            cnt_d = cnt_q + {{(R-1){1'b0}}, 1'b1};
            if (wrap_s) begin
                amp_lat_d = amp_clamp_s;
                for (int c = 0; c < NCH; c++) begin
                    duty_d[c] = duty_of(chan_idx(step_next_s, c), amp_clamp_s);
                end
                if (step_adv_s) begin
                    nper_d  = 12'd0;
                    step_d  = step_next_s;
                    n_lat_d = ndiv_eff_s;
                end else begin
                    nper_d  = nper_q + 12'd1;
                end
            end else begin
                amp_lat_d = amp_lat_q;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset to step 0 at full amplitude.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            nper_q    <= 12'd0;
            step_q    <= 6'd0;
            n_lat_q   <= 12'd1;
            amp_lat_q <= 9'd256;
            for (int c = 0; c < NCH; c++) begin
                duty_q[c] <= duty_of(chan_idx(6'd0, c), 9'd256);
            end
        end else begin
            cnt_q     <= cnt_d;
            nper_q    <= nper_d;
            step_q    <= step_d;
            n_lat_q   <= n_lat_d;
            amp_lat_q <= amp_lat_d;
            duty_q    <= duty_d;
        end
    end

    // Output compare and tick decode from the registered carrier state.
    always_comb begin
        pwm_out = '0;
        for (int c = 0; c < NCH; c++) begin
            pwm_out[c] = en && (cnt_q < duty_q[c]);
        end
        step_idx    = step_q;
        period_tick = wrap_s;
        step_tick   = step_adv_s;
    end

endmodule

// File: tb/tb_pwm_sine_multich.sv
// Self-checking bench for pwm_sine_multich: directed scenarios plus random
// stimulus, all outputs compared every cycle against a behavioural model.
module tb_pwm_sine_multich;

    localparam int R     = 6;
    localparam int NCH   = 3;
    localparam int PHASE = 12;
    localparam int P     = 1 << R;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b0;
    logic [11:0]     n_div = 12'd1;
    logic [8:0]      amp = 9'd256;
    logic [NCH-1:0]  pwm_out;
    logic [5:0]      step_idx;
    logic            period_tick;
    logic            step_tick;

    pwm_sine_multich #(.R(R), .NCH(NCH), .PHASE(PHASE)) dut (
        .clk(clk), .rst(rst), .en(en), .n_div(n_div), .amp(amp),
        .pwm_out(pwm_out), .step_idx(step_idx),
        .period_tick(period_tick), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference sine table built from the defining formula.
    int sinq [36];
    initial begin
        for (int k = 0; k < 36; k++) begin
            sinq[k] = $rtoi($floor(1023.0 * (0.5 + 0.5 * $sin(2.0 * 3.14159265358979 * k / 36.0)) + 0.5));
        end
    end

    function automatic int dmodel(int k, int a);
        int s;
        int d;
        s = sinq[k] - 512;
        d = 512 + $rtoi($floor(real'(s * a) / 256.0));
        if (d < 0) d = 0;
        if (d > 1023) d = 1023;
        return d / (1 << (10 - R));
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    int m_cnt, m_nper, m_step, m_nlat;
    int m_duty [NCH];
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_nper <= 0;
            m_step <= 0;
            m_nlat <= 1;
            for (int c = 0; c < NCH; c++) m_duty[c] <= dmodel((c * PHASE) % 36, 256);
            m_valid <= 1'b1;
        end else if (en) begin
            m_cnt <= (m_cnt + 1) % P;
            if (m_cnt == P - 1) begin
                for (int c = 0; c < NCH; c++)
                    m_duty[c] <= dmodel(((m_nper == m_nlat - 1 ? (m_step + 1) % 36 : m_step) + c * PHASE) % 36,
                                        (amp > 9'd256) ? 256 : int'(amp));
                if (m_nper == m_nlat - 1) begin
                    m_nper <= 0;
                    m_step <= (m_step + 1) % 36;
                    m_nlat <= (n_div == 12'd0) ? 1 : int'(n_div);
                end else begin
                    m_nper <= m_nper + 1;
                end
            end
        end
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            int ep;
            ep = 0;
            for (int c = 0; c < NCH; c++)
                if (en && (m_cnt < m_duty[c])) ep = ep | (1 << c);
            check("pwm_out", int'(pwm_out), ep);
            check("step_idx", int'(step_idx), m_step);
            check("period_tick", int'(period_tick), int'(en && m_cnt == P - 1));
            check("step_tick", int'(step_tick), int'(en && m_cnt == P - 1 && m_nper == m_nlat - 1));
        end
    end

    int hi [NCH];
    int tick_at;

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Count high cycles per channel over n cycles; ends 1 time unit past a posedge.
    task automatic measure(input int n);
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        tick_at = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            for (int c = 0; c < NCH; c++) if (pwm_out[c]) hi[c]++;
            if (step_tick && tick_at < 0) tick_at = i;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        // Model anchors
        check("sinq0", sinq[0], 512);
        check("sinq9", sinq[9], 1023);
        check("sinq18", sinq[18], 512);
        check("sinq27", sinq[27], 0);
        check("d_amp128_step9", dmodel(9, 128), 47);
        check("d_amp0_step9", dmodel(9, 0), 32);

        // First period after reset
        n_div = 12'd1;
        amp   = 9'd256;
        do_reset();
        en = 1'b1;
        measure(P);
        check("w0_ch0", hi[0], 32);
        check("w0_ch1", hi[1], 59);
        check("w0_ch2", hi[2], 4);
        check("first_step_tick_clk", tick_at, 63);
        measure(P);
        check("w1_ch0", hi[0], 37);

        // Mid-period change of n_div and amp
        cycles(10);
        n_div = 12'd4;
        amp   = 9'd0;
        cycles(P - 10);
        measure(P);
        check("amp0_ch0", hi[0], 32);
        check("amp0_ch1", hi[1], 32);
        check("amp0_ch2", hi[2], 32);

        // en drop for 100 clocks mid-period
        amp   = 9'd256;
        n_div = 12'd1;
        do_reset();
        en = 1'b1;
        cycles(20);
        en = 1'b0;
        measure(100);
        check("drop_hi", hi[0] + hi[1] + hi[2], 0);
        en = 1'b1;
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        for (int i = 0; i < P - 20; i++) begin
            @(negedge clk);
            if (pwm_out[1]) hi[1]++;
        end
        check("resume_ch1_remain", hi[1], 39);
        cycles(1);

        // Reset mid-step at step 20
        begin
            int guard;
            guard = 0;
            while (m_step != 20 && guard < 3000) begin
                cycles(1);
                guard++;
            end
            check("reach_step20", m_step, 20);
        end
        cycles(17);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_step_idx", int'(step_idx), 0);
        check("rst_pwm", int'(pwm_out), 7);
        cycles(1);

        // Full sine at n_div=3
        n_div = 12'd3;
        cycles(36 * 3 * P + 2 * P);

        // Random stimulus
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 49) == 0) n_div = 12'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) amp = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 19) == 0) en = ~en;
            rst = ($urandom_range(0, 999) == 0);
            cycles(1);
        end
        rst = 1'b0;
        cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
